// File: rtl/data_mem_sync.sv
// data_mem_sync: byte-addressed big-endian RAM with fixed access latency and range/alignment error checking
// Ports: clk, rst (sync, active-high); req_valid/req_ready handshake with we, size, addr, wdata;
//        response rsp_valid (one-cycle pulse) with rdata (right-aligned, zero-extended) and err.
module data_mem_sync #(
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rsp_valid,
    output logic        err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      state;
    logic [3:0]  cnt;
    logic        r_we;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata;
    logic [7:0]  mem [DEPTH];
    logic        c_we, bad, go_resp;
    logic [1:0]  c_size;
    logic [31:0] c_addr, c_wdata, rd;
    logic [33:0] last, lim;
    logic [AW-1:0] i0, i1, i2, i3;
    assign req_ready = (state == IDLE);
    // With zero wait cycles the access completes on the accepting edge, so the live bus is used directly
    always_comb begin
        c_we    = (state == IDLE) ? we : r_we;
        c_size  = (state == IDLE) ? size : r_size;
        c_addr  = (state == IDLE) ? addr : r_addr;
        c_wdata = (state == IDLE) ? wdata : r_wdata;
        // 34-bit arithmetic so the end-of-access address cannot wrap past zero
        last    = {2'b00, c_addr} + ((c_size == 2'd2) ? 34'd3 : (c_size == 2'd1) ? 34'd1 : 34'd0);
        lim     = {2'b00, BASE_ADDR} + 34'(DEPTH);
        bad     = (c_size == 2'd3) || (c_addr < BASE_ADDR) || (last >= lim) ||
                  (c_size == 2'd1 && c_addr[0]) || (c_size == 2'd2 && c_addr[1:0] != 2'b00);
        i0      = AW'(c_addr - BASE_ADDR);
        i1      = i0 + AW'(1);
        i2      = i0 + AW'(2);
        i3      = i0 + AW'(3);
        rd      = (c_size == 2'd2) ? {mem[i0], mem[i1], mem[i2], mem[i3]} :
                  (c_size == 2'd1) ? {16'd0, mem[i0], mem[i1]} : {24'd0, mem[i0]};
        go_resp = (state == IDLE && req_valid && WAIT_CYCLES == 0) || (state == WAIT && cnt == 4'd0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            err       <= 1'b0;
            rdata     <= 32'd0;
        end else begin
            rsp_valid <= go_resp;
            if (go_resp) begin
                err   <= bad;
                rdata <= bad ? 32'd0 : rd;
            end
            case (state)
                IDLE: if (req_valid) begin
                    r_we    <= we;
                    r_size  <= size;
                    r_addr  <= addr;
                    r_wdata <= wdata;
                    state   <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    cnt     <= (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
                end
                WAIT: if (cnt == 4'd0) state <= RESP; else cnt <= cnt - 4'd1;
                default: state <= IDLE;
            endcase
        end
    end
    // RAM is never cleared; reset only suppresses a pending write
    always_ff @(posedge clk) begin
        if (!rst && go_resp && c_we && !bad) begin
            if (c_size == 2'd2) begin
                mem[i0] <= c_wdata[31:24];
                mem[i1] <= c_wdata[23:16];
                mem[i2] <= c_wdata[15:8];
                mem[i3] <= c_wdata[7:0];
            end else if (c_size == 2'd1) begin
                mem[i0] <= c_wdata[15:8];
                mem[i1] <= c_wdata[7:0];
            end else begin
                mem[i0] <= c_wdata[7:0];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_sync.sv
// tb_data_mem_sync: vector table, random traffic against a byte-array model, and timing/reset sequences
module tb_data_mem_sync;
    localparam logic [31:0] BASE = 32'd1024;
    localparam int DEPTH = 1024;
    localparam int WC = 2;
    logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, we = 1'b0;
    logic [1:0] size = 2'd0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [31:0] rdata;
    logic req_ready, rsp_valid, err;
    int checks = 0, failures = 0;
    logic [7:0] mm [DEPTH];
    typedef struct {
        bit          w;
        logic [1:0]  s;
        logic [31:0] a;
        logic [31:0] d;
        bit          chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;
    vec_t tv[17];
    always #5 clk = ~clk;
    data_mem_sync #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .we(we), .size(size),
        .addr(addr), .wdata(wdata), .rdata(rdata), .rsp_valid(rsp_valid), .err(err)
    );
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
        end
    endtask
    function automatic void model(input bit w, input logic [1:0] s, input logic [31:0] a,
                                  input logic [31:0] d, output logic [31:0] rd, output logic e);
        int n;
        longint lo, base;
        n = (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
        lo = longint'({32'd0, a});
        base = longint'({32'd0, BASE});
        e = (s == 2'd3) || (lo < base) || (lo + n - 1 >= base + DEPTH) || (lo % n != 0);
        rd = 32'd0;
        if (!e)
            for (int i = 0; i < n; i++) begin
                int k;
                k = int'(lo - base) + i;
                if (w) mm[k] = d[8*(n-1-i) +: 8];
                else rd = {rd[23:0], mm[k]};
            end
    endfunction
    task automatic do_req(input bit w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic e);
        int n;
        bit got;
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; we = w; size = s; addr = a; wdata = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0; we = 1'($urandom); size = 2'($urandom); addr = $urandom; wdata = $urandom;
        got = 1'b0;
        n = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            chk("busy_ready", 32'(req_ready), 32'd0);
            if (rsp_valid) got = 1'b1;
        end
        chk("latency", n, 1 + WC);
        rd = rdata;
        e = err;
        @(negedge clk);
        chk("pulse_len", 32'(rsp_valid), 32'd0);
        chk("hold_rdata", rdata, rd);
        chk("hold_err", 32'(err), 32'(e));
    endtask
    task automatic run(input string nm, input bit w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] ed, gd;
        logic ee, ge;
        model(w, s, a, d, ed, ee);
        do_req(w, s, a, d, gd, ge);
        chk({nm, "_err"}, 32'(ge), 32'(ee));
        if (!w || ee) chk({nm, "_rdata"}, gd, ed);
    endtask
    initial begin
        logic [31:0] gd, md, a;
        logic ge, me;
        int resp;
        tv[0]  = '{1, 2'd2, 32'h400, 32'hDEADBEEF, 0, 32'h0, 0};
        tv[1]  = '{0, 2'd0, 32'h401, 32'h0, 1, 32'h000000AD, 0};
        tv[2]  = '{1, 2'd1, 32'h402, 32'h00001234, 0, 32'h0, 0};
        tv[3]  = '{0, 2'd2, 32'h400, 32'h0, 1, 32'hDEAD1234, 0};
        tv[4]  = '{1, 2'd2, 32'h402, 32'hFFFFFFFF, 1, 32'h0, 1};
        tv[5]  = '{0, 2'd2, 32'h400, 32'h0, 1, 32'hDEAD1234, 0};
        tv[6]  = '{0, 2'd2, 32'h7FC, 32'h0, 1, 32'h0, 0};
        tv[7]  = '{0, 2'd2, 32'h7FE, 32'h0, 1, 32'h0, 1};
        tv[8]  = '{0, 2'd0, 32'h3FF, 32'h0, 1, 32'h0, 1};
        tv[9]  = '{0, 2'd2, 32'h800, 32'h0, 1, 32'h0, 1};
        tv[10] = '{0, 2'd1, 32'h7FE, 32'h0, 1, 32'h0, 0};
        tv[11] = '{0, 2'd0, 32'h7FF, 32'h0, 1, 32'h0, 0};
        tv[12] = '{0, 2'd1, 32'h401, 32'h0, 1, 32'h0, 1};
        tv[13] = '{0, 2'd3, 32'h400, 32'h0, 1, 32'h0, 1};
        tv[14] = '{1, 2'd0, 32'h7FF, 32'h123456A5, 0, 32'h0, 0};
        tv[15] = '{0, 2'd0, 32'h7FF, 32'h0, 1, 32'h000000A5, 0};
        tv[16] = '{0, 2'd2, 32'hFFFFFFFC, 32'h0, 1, 32'h0, 1};
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        for (int i = 0; i < DEPTH / 4; i++) run("prefill", 1'b1, 2'd2, BASE + 32'(4 * i), 32'd0);
        for (int i = 0; i < 17; i++) begin
            model(tv[i].w, tv[i].s, tv[i].a, tv[i].d, md, me);
            do_req(tv[i].w, tv[i].s, tv[i].a, tv[i].d, gd, ge);
            chk($sformatf("vec%0d_err", i), 32'(ge), 32'(tv[i].exp_err));
            if (tv[i].chk_rd) chk($sformatf("vec%0d_rdata", i), gd, tv[i].exp_rd);
        end
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 3) == 0) ? $urandom : BASE - 32'd8 + 32'($urandom_range(0, DEPTH + 15));
            if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
            run("rand", 1'($urandom), 2'($urandom), a, $urandom);
        end
        model(1'b0, 2'd2, 32'h400, 32'd0, md, me);
        resp = 0;
        @(negedge clk);
        req_valid = 1'b1; we = 1'b0; size = 2'd2; addr = 32'h400; wdata = 32'd0;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) @(negedge clk);
            chk($sformatf("b2b_ready_c%0d", c), 32'(req_ready), 32'((c % 4 == 0) || c >= 12));
            chk($sformatf("b2b_rsp_c%0d", c), 32'(rsp_valid), 32'(c == 3 || c == 7 || c == 11));
            if (rsp_valid) begin
                resp++;
                chk("b2b_rdata", rdata, md);
            end
            if (c == 9) req_valid = 1'b0;
        end
        chk("b2b_count", resp, 3);
        run("pre_rst_wr", 1'b1, 2'd2, 32'h404, 32'h22222222);
        @(negedge clk);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h404; wdata = 32'h11111111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_ready_after", 32'(req_ready), 32'd1);
        resp = 0;
        for (int c = 0; c < 6; c++) begin
            if (rsp_valid) resp++;
            @(negedge clk);
        end
        chk("mid_rst_no_rsp", resp, 0);
        do_req(1'b0, 2'd2, 32'h404, 32'd0, gd, ge);
        chk("mid_rst_kept", gd, 32'h22222222);
        chk("mid_rst_kept_err", 32'(ge), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/data_mem_sync.md
DATA_MEM_SYNC -- requirements
Module: data_mem_sync

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'd1024, byte address of the first RAM byte.
REQ-002 SHALL have parameter DEPTH, default 1024, RAM size in bytes; power of two, 4..65536.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2, added access latency in cycles; legal range 0..15.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port req_valid, input, 1, request present.
REQ-007 SHALL have port req_ready, output, 1, block can accept a request this cycle.
REQ-008 SHALL have port we, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port size, input, 2, 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-010 SHALL have port addr, input, 32, byte address.
REQ-011 SHALL have port wdata, input, 32, write data, right-aligned.
REQ-012 SHALL have port rdata, output, 32, read data, right-aligned and zero-extended.
REQ-013 SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port err, output, 1, error flag, qualified by rsp_valid.

Function
REQ-015 SHALL be an FSM with states IDLE, WAIT and RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on a cycle T with req_valid && req_ready, latching we, size, addr and wdata.
- req, size, addr and wdata changes after T SHALL have no effect.
REQ-017 SHALL go from IDLE to WAIT after acceptance, or to RESP directly when WAIT_CYCLES = 0.
- WAIT counts down WAIT_CYCLES cycles, then goes to RESP.
- RESP lasts one cycle, then returns to IDLE.
REQ-018 SHALL assert rsp_valid for exactly one cycle, at T+1+WAIT_CYCLES.
- Throughput: one request per WAIT_CYCLES+2 cycles.
REQ-019 SHALL perform the RAM write, and capture rdata, on the clock edge that enters RESP.
REQ-020 SHALL store bytes big-endian: byte at address A is the most significant byte of the word or halfword.
- Word write: RAM[A..A+3] = wdata[31:24], [23:16], [15:8], [7:0].
- Halfword write: RAM[A..A+1] = wdata[15:8], [7:0].
- Byte write: RAM[A] = wdata[7:0].
REQ-021 SHALL index the RAM as addr - BASE_ADDR, computed in 32 bits.
REQ-022 SHALL flag an error when any of the following holds:
- addr < BASE_ADDR;
- addr + nbytes - 1 >= BASE_ADDR + DEPTH, with no 32-bit wrap;
- a halfword access has addr[0] = 1;
- a word access has addr[1:0] != 0;
- size = 11.
REQ-023 On an error response SHALL drive err = 1, rdata = 0 and leave the RAM unmodified.
REQ-024 SHALL hold rdata and err stable from the RESP cycle until the next RESP cycle.
REQ-025 SHALL ignore req_valid while in WAIT or RESP; such requests are neither accepted nor queued.
REQ-026 SHALL, for a read after a write to the same bytes, return the newly written data.

Reset
REQ-027 While rst = 1 at a clock edge, the block SHALL enter IDLE with rsp_valid = 0, err = 0, rdata = 0 and the wait counter = 0.
REQ-028 SHALL drive req_ready = 1 on the first cycle after rst deasserts.
REQ-029 RAM contents SHALL NOT be cleared by rst.
REQ-030 Reset asserted in WAIT SHALL abandon the request: no RAM write and no rsp_valid.

Verification
REQ-031 Word write and byte read: write word 0xDEADBEEF to 0x400 accepted at T -> rsp_valid=1, err=0 at T+3. Then byte read of 0x401 -> rdata=0x000000AD.
REQ-032 Halfword merge: halfword write 0x1234 to 0x402, then word read of 0x400 -> rdata=0xDEAD1234, err=0.
REQ-033 Misaligned word: word write of 0xFFFFFFFF to 0x402 -> err=1, rdata=0. Word read of 0x400 still returns 0xDEAD1234.
REQ-034 Range boundaries: word read of 0x7FC -> err=0. Word read of 0x7FE -> err=1. Byte read of 0x3FF -> err=1. Word read of 0x800 -> err=1.
REQ-035 Busy and back-to-back: req_valid held high for 10 cycles -> exactly 3 responses, at T+3, T+7 and T+11. req_ready = 0 during every WAIT and RESP cycle.
REQ-036 Reset mid-write: word write 0x11111111 to 0x404, rst pulsed at T+1 -> no rsp_valid, req_ready=1 after reset, and the word at 0x404 keeps its previous value.
